// File: rtl/skolem_chk_pkg.sv
// Shared types and the bvult/bvadd invertibility and violation rules for the
// Skolem sweep checker.
package skolem_chk_pkg;

  localparam int unsigned CHK_W = 4;
  localparam int unsigned NVEC  = 2**(2*CHK_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } sweep_state_t;

  // s does not affect this condition but stays in the (s,t) signature.
  function automatic logic ic_bvult_bvadd(input logic [CHK_W-1:0] s,
                                          input logic [CHK_W-1:0] t);
    return (t != '0) | (1'b0 & (^s));
  endfunction

  function automatic logic viol_bvult_bvadd(input logic [CHK_W-1:0] x,
                                            input logic [CHK_W-1:0] s,
                                            input logic [CHK_W-1:0] t);
    logic [CHK_W-1:0] sum;
    sum = x + s;
    return ic_bvult_bvadd(s, t) && !(sum < t);
  endfunction

endpackage

// File: rtl/skolem_chk_if.sv
// Stimulus/response and result bundle between the sweep checker (slave) and
// its environment driving start and the candidate output (master).
interface skolem_chk_if
  import skolem_chk_pkg::*;
#(
  parameter int unsigned W     = CHK_W,
  parameter int unsigned CNT_W = 2*W+1
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic             stim_valid;
  logic [W-1:0]     stim_s;
  logic [W-1:0]     stim_t;
  logic [W-1:0]     cand_x;
  logic [CNT_W-1:0] fail_cnt;
  logic             first_fail_valid;
  logic [W-1:0]     first_fail_s;
  logic [W-1:0]     first_fail_t;
  logic [W-1:0]     first_fail_x;

  modport master (
    output start, cand_x,
    input  busy, done, pass, stim_valid, stim_s, stim_t, fail_cnt,
           first_fail_valid, first_fail_s, first_fail_t, first_fail_x
  );

  modport slave (
    input  start, cand_x,
    output busy, done, pass, stim_valid, stim_s, stim_t, fail_cnt,
           first_fail_valid, first_fail_s, first_fail_t, first_fail_x
  );
endinterface

// File: rtl/skolem_vec_gen.sv
// Sweep index counter: cleared on start, advanced on request, and flags the
// final vector; it never wraps so the last presented vector stays visible.
module skolem_vec_gen
  import skolem_chk_pkg::*;
#(
  parameter int unsigned IDX_W = 2*CHK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             adv,
  output logic [IDX_W-1:0] idx,
  output logic             last
);
  logic [IDX_W-1:0] idx_q, idx_d;

  assign last = (idx_q == IDX_W'(NVEC-1));
  assign idx  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clear)
      idx_d = '0;
    else if (adv && !last)
      idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end
endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive (s,t) sweep harness for a find_inv bvult/bvadd Skolem candidate.
// SKOLEM_CHK_STOP_ON_FAIL_EN: end the sweep at the first violation.
module skolem_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int unsigned W     = CHK_W,
  parameter int unsigned CNT_W = 2*W+1
) (
  input logic         clk,
  input logic         rst,
  skolem_chk_if.slave bus
);
  sweep_state_t     state_q, state_d;
  logic             chk_v_q, chk_v_d;
  logic [W-1:0]     chk_s_q, chk_s_d, chk_t_q, chk_t_d, chk_x_q, chk_x_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             ffv_q, ffv_d, pass_q, pass_d;
  logic [W-1:0]     ffs_q, ffs_d, fft_q, fft_d, ffx_q, ffx_d;

  logic [2*W-1:0]   idx;
  logic             last, clear, adv, viol, stop_hit;

  assign clear = (state_q == ST_IDLE) && bus.start;
  // Hold the index when leaving SWEEP so stim_* keep the last presented vector.
  assign adv   = (state_q == ST_SWEEP) && (state_d == ST_SWEEP);
  assign viol  = chk_v_q && viol_bvult_bvadd(chk_x_q, chk_s_q, chk_t_q);

`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
  assign stop_hit = viol;
`else
  assign stop_hit = 1'b0;
`endif

  skolem_vec_gen #(.IDX_W(2*W)) u_vec_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .adv   (adv),
    .idx   (idx),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SWEEP;
      ST_SWEEP: if (last || stop_hit) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    chk_v_d    = (state_q == ST_SWEEP);
    chk_s_d    = bus.stim_s;
    chk_t_d    = bus.stim_t;
    chk_x_d    = bus.cand_x;
    fail_cnt_d = fail_cnt_q;
    ffv_d      = ffv_q;
    ffs_d      = ffs_q;
    fft_d      = fft_q;
    ffx_d      = ffx_q;
    pass_d     = pass_q;
    if (clear) begin
      fail_cnt_d = '0;
      ffv_d      = 1'b0;
      ffs_d      = '0;
      fft_d      = '0;
      ffx_d      = '0;
      pass_d     = 1'b0;
    end else if (viol) begin
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      if (!ffv_q) begin
        ffv_d = 1'b1;
        ffs_d = chk_s_q;
        fft_d = chk_t_q;
        ffx_d = chk_x_q;
      end
    end
    // The final compare retires in DRAIN, so pass sees the updated count.
    if (state_q == ST_DRAIN) pass_d = (fail_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      chk_v_q    <= 1'b0;
      chk_s_q    <= '0;
      chk_t_q    <= '0;
      chk_x_q    <= '0;
      fail_cnt_q <= '0;
      ffv_q      <= 1'b0;
      ffs_q      <= '0;
      fft_q      <= '0;
      ffx_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_v_q    <= chk_v_d;
      chk_s_q    <= chk_s_d;
      chk_t_q    <= chk_t_d;
      chk_x_q    <= chk_x_d;
      fail_cnt_q <= fail_cnt_d;
      ffv_q      <= ffv_d;
      ffs_q      <= ffs_d;
      fft_q      <= fft_d;
      ffx_q      <= ffx_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.busy             = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign bus.done             = (state_q == ST_DONE);
  assign bus.pass             = pass_q;
  assign bus.stim_valid       = (state_q == ST_SWEEP);
  assign bus.stim_s           = idx[W-1:0];
  assign bus.stim_t           = idx[2*W-1:W];
  assign bus.fail_cnt         = fail_cnt_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_s     = ffs_q;
  assign bus.first_fail_t     = fft_q;
  assign bus.first_fail_x     = ffx_q;
endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Sweep checker bench: candidate models driven combinationally, results
// compared against a whole-sweep reference computed with plain arithmetic.
module tb_skolem_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   mode   = 0;
  logic [3:0] lut [256];
  int   stop_en;

  skolem_chk_if #(.W(4), .CNT_W(9)) bus ();

  skolem_sweep_checker #(.W(4), .CNT_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       bus.cand_x = bus.stim_t - 4'd1 - bus.stim_s;
      1:       bus.cand_x = 4'd0;
      2:       bus.cand_x = bus.stim_t - bus.stim_s;
      default: bus.cand_x = lut[{bus.stim_t, bus.stim_s}];
    endcase
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_x(input int m, input int i);
    int s, t;
    s = i % 16;
    t = i / 16;
    case (m)
      0:       return (t - 1 - s) & 15;
      1:       return 0;
      2:       return (t - s) & 15;
      default: return int'(lut[i]);
    endcase
  endfunction

  // Reference over vectors 0..lim: violation count, first failing index,
  // done cycle and the index left on stim_* at the end.
  task automatic expect_sweep(input int m, input int lim, output int cnt,
                              output int first, output int done_cyc,
                              output int last_idx);
    int s, t, x;
    cnt = 0;
    first = -1;
    for (int i = 0; i <= lim; i++) begin
      if (stop_en != 0 && first >= 0 && i > first + 1) break;
      s = i % 16;
      t = i / 16;
      x = model_x(m, i);
      if (t != 0 && !(((x + s) % 16) < t)) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    done_cyc = 258;
    last_idx = 255;
    if (stop_en != 0 && first >= 0) begin
      done_cyc = (first + 4 < 258) ? first + 4 : 258;
      last_idx = (first < 255) ? first + 1 : 255;
    end
  endtask

  task automatic run_sweep(input int m, input int restart_at, input string tag);
    int cnt, first, done_cyc, last_idx, n, seen;
    mode = m;
    expect_sweep(m, 255, cnt, first, done_cyc, last_idx);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    seen = 0;
    while (n <= 400) begin
      @(negedge clk);
      if (n == 2) check_eq({tag, "_busy_run"}, int'(bus.busy), 1);
      if (bus.done) begin
        seen = 1;
        break;
      end
      bus.start = (n == restart_at);
      @(posedge clk);
      n++;
    end
    bus.start = 1'b0;
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_done_cycle"}, n, done_cyc);
    check_eq({tag, "_busy_done"}, int'(bus.busy), 0);
    check_eq({tag, "_stim_valid"}, int'(bus.stim_valid), 0);
    check_eq({tag, "_stim_hold"}, int'({bus.stim_t, bus.stim_s}), last_idx);
    check_eq({tag, "_pass"}, int'(bus.pass), (cnt == 0) ? 1 : 0);
    check_eq({tag, "_fail_cnt"}, int'(bus.fail_cnt), cnt);
    check_eq({tag, "_ff_valid"}, int'(bus.first_fail_valid), (first >= 0) ? 1 : 0);
    check_eq({tag, "_ff_s"}, int'(bus.first_fail_s), (first >= 0) ? first % 16 : 0);
    check_eq({tag, "_ff_t"}, int'(bus.first_fail_t), (first >= 0) ? first / 16 : 0);
    check_eq({tag, "_ff_x"}, int'(bus.first_fail_x), (first >= 0) ? model_x(m, first) : 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, int'(bus.done), 0);
    check_eq({tag, "_pass_hold"}, int'(bus.pass), (cnt == 0) ? 1 : 0);
    check_eq({tag, "_cnt_hold"}, int'(bus.fail_cnt), cnt);
  endtask

  task automatic run_reset_abort();
    int cnt, first, done_cyc, last_idx, n, dones;
    mode = 1;
    // At cycle 100 the counters reflect compares of vectors 0..97.
    expect_sweep(1, 97, cnt, first, done_cyc, last_idx);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    while (n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("abort_cnt_before", int'(bus.fail_cnt), cnt);
    check_eq("abort_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", int'(bus.busy), 0);
    check_eq("abort_fail_cnt", int'(bus.fail_cnt), 0);
    check_eq("abort_stim_valid", int'(bus.stim_valid), 0);
    check_eq("abort_stim", int'({bus.stim_t, bus.stim_s}), 0);
    check_eq("abort_ff_valid", int'(bus.first_fail_valid), 0);
    dones = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
  endtask

  initial begin
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
    stop_en = 1;
`else
    stop_en = 0;
`endif
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) lut[i] = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_pass", int'(bus.pass), 0);
    check_eq("rst_stim_valid", int'(bus.stim_valid), 0);
    check_eq("rst_stim", int'({bus.stim_t, bus.stim_s}), 0);
    check_eq("rst_fail_cnt", int'(bus.fail_cnt), 0);
    check_eq("rst_ff_valid", int'(bus.first_fail_valid), 0);

    run_sweep(0, -1, "correct");
    run_sweep(1, -1, "stuck0");
    run_sweep(2, -1, "t_minus_s");
    run_sweep(1, 50, "restart");
    run_reset_abort();
    run_sweep(0, -1, "post_rst");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 7) == 0)
          lut[i] = 4'($urandom);
        else
          lut[i] = 4'(((i / 16) - 1 - (i % 16)) & 15);
      end
      run_sweep(3, int'($urandom_range(2, 200)), $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
